dmem_access_unit: RTL

- MEM-stage data memory responder for the pipelined MIPS core.
- Accepts load/store requests from the EX/MEM register and models a fixed multi-cycle memory latency with an internal word array.
- Stalls the pipeline until the access completes, then drives the read data consumed by the MEM/WB register.
- It is the producer side of the MEM/WB memory-data interface.

---
 rtl/dmem_access_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory responder: fixed-latency word array that stalls the pipeline per access.
// Optional DMEM_STATS_EN adds saturating load/store/stall counters.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misaligned_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_count_o,
    output logic [15:0] store_count_o,
    output logic [15:0] stall_count_o
`endif
);

    // state  | meaning
    // IDLE   | waiting for a request; aligned request starts an access
    // ACCESS | counting down the memory latency on latched request values
    // DONE   | access finished, load data valid on rdata_o
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic                  r_is_store;
    logic [31:0]           r_rdata;
    logic                  r_misaligned;
    logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

    wire w_req         = mem_read_i | mem_write_i;
    wire w_aligned     = (addr_i[1:0] == 2'b00);
    wire w_start       = (r_state == S_IDLE) && w_req && w_aligned;
    wire w_fire        = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    wire w_unused_addr = ^addr_i[31:ADDR_WIDTH+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
            r_is_store   <= 1'b0;
            r_rdata      <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_aligned) begin
                            r_idx        <= addr_i[ADDR_WIDTH+1:2];
                            r_wdata      <= wdata_i;
                            r_is_store   <= mem_write_i;
                            r_cnt        <= CNT_INIT;
                            r_misaligned <= 1'b0;
                            r_state      <= S_ACCESS;
                        end else begin
                            r_misaligned <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_is_store) r_rdata <= r_mem[r_idx];
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; a reset mid-access leaves the FSM in IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (w_fire && r_is_store) r_mem[r_idx] <= r_wdata;
    end

    assign stall_o      = reset & (w_start | (r_state == S_ACCESS));
    assign rdata_o      = r_rdata;
    assign misaligned_o = r_misaligned;

`ifdef DMEM_STATS_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_cnt  <= 16'd0;
            r_store_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_fire) begin
                if (r_is_store) begin
                    if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
                end else begin
                    if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
                end
            end
            if (stall_o && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign load_count_o  = r_load_cnt;
    assign store_count_o = r_store_cnt;
    assign stall_count_o = r_stall_cnt;
`endif

endmodule
